rf_writeback: RTL and testbench
===============================

// Module: rf_writeback
// PURPOSE
//  Writeback stage directly upstream of the RF write port: accepts results from the ALU and memory
//  pipes, arbitrates them onto the single RF write port, and buffers ALU results in a small FIFO
//  on collision. Optionally bypasses the in-flight write onto RF read data (same-cycle RAW).
// PARAMETERS
//  entries        4   RF depth; address width AW = $clog2(entries)
//  data_bus_size  8   data width DW
//  read_ports     2   RF read ports covered by bypass
//  fifo_depth     2   ALU skid FIFO depth (>=1)
// PORTS
//  clock        in   1                 single clock, rising edge
//  reset        in   1                 synchronous, active-high
//  alu_valid    in   1                 ALU result valid
//  alu_ready    out  1                 = FIFO not full (registered count only)
//  alu_dst      in   AW                ALU destination register
//  alu_data     in   DW                ALU result
//  mem_valid    in   1                 load result valid
//  mem_ready    out  1                 0 only when FIFO full
//  mem_dst      in   AW                load destination
//  mem_data     in   DW                load data
//  wr_en        out  [1] x 1           to RF wr_en (unpacked, write_ports=1)
//  dst          out  [1] x AW          to RF dst
//  datain       out  [1] x DW          to RF datain
//  rd_src       in   [read_ports] x AW copy of RF src
//  rf_dataout   in   [read_ports] x DW RF dataout
//  rd_data      out  [read_ports] x DW operand data to consumer
//  fifo_count   out  $clog2(fifo_depth+1) ALU FIFO occupancy
// BEHAVIOUR
//  - Reset (sync): wr_en=0, dst=0, datain=0, FIFO emptied, fifo_count=0; accepted-but-unwritten
//    results are dropped; reset asserted mid-burst wins over all inputs that cycle.
//  - Handshake: transfer when valid&&ready at rising edge; producers hold dst/data while valid&&!ready.
//  - One winner per cycle, fixed priority:
//    1) FIFO full  -> FIFO head wins, mem_ready=0, alu_ready=0.
//    2) mem_valid  -> MEM wins; ALU input (if valid & ready) is enqueued.
//    3) FIFO non-empty -> head wins; ALU input enqueued behind it (order kept).
//    4) alu_valid, FIFO empty -> ALU direct, FIFO untouched.
//    5) none -> wr_en=0 next cycle; dst/datain hold last value.
//  - Latency: winner is registered onto wr_en/dst/datain; visible cycle N+1, RF commits at end of N+1.
//  - FIFO: enqueue+dequeue in same cycle leaves count unchanged; pointers wrap modulo fifo_depth;
//    never overflows (alu_ready=0 when full) nor underflows (pop only when count>0).
//  - Same dst written by MEM and ALU in consecutive cycles: committed in arbitration order;
//    WAW ordering across pipes is owned by the issue stage.
//  - No register is special-cased; dst=0 is written like any other.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined: rd_data[i] = (wr_en[0] && rd_src[i]==dst[0]) ? datain[0] : rf_dataout[i],
//    purely combinational, per port independently.
//  Not defined: rd_data[i] = rf_dataout[i]; ports remain, rd_src ignored.
// STRUCTURE
//  rf_pkg: BUS_SIZE, ENTRIES constants; typedef struct packed {logic [AW-1:0] dst;
//    logic [DW-1:0] data;} wb_entry_t; wb_src_e {WB_NONE, WB_MEM, WB_FIFO, WB_ALU}.
//  Sub-module wb_fifo (parameterised depth, wb_entry_t payload, push/pop/count/full/empty).
//  Arbitration and output register stay in rf_writeback.
// TESTING (bench instantiates rf_writeback + RF, entries=4, bus 8, read_ports 2)
//  1 reset then alu_valid, dst=3,data=47 one cycle -> wr_en=1,dst=3,datain=47 next cycle; RF[3]=47 after.
//  2 mem(dst=1,5) and alu(dst=2,9) same cycle -> cycle+1 writes R1=5, cycle+2 writes R2=9, count 1->0.
//  3 mem_valid held 4 cycles + alu_valid every cycle -> count reaches 2, alu_ready=0, mem_ready=0,
//    FIFO head written, then MEM resumes; all 8 results land, FIFO order preserved.
//  4 reset asserted with fifo_count=2 and wr_en=1 -> next cycle wr_en=0, count=0; no further writes.
//  5 BYPASS_EN: RF[3]=0, write 3<-47 in flight, rd_src[1]=3 -> rd_data[1]=47 same cycle;
//    without macro rd_data[1]=0 that cycle, 47 the cycle after.
//  6 idle 3 cycles after write -> wr_en=0, dst/datain hold, RF contents unchanged.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file writeback constants, payload struct and source encoding
package rf_pkg;
    localparam int ENTRIES  = 4;
    localparam int BUS_SIZE = 8;
    localparam int AW       = $clog2(ENTRIES);
    localparam int DW       = BUS_SIZE;

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {WB_NONE, WB_MEM, WB_FIFO, WB_ALU} wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small circular skid FIFO holding ALU results that lost arbitration
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  wb_entry_t       din,
    output wb_entry_t       dout,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // payload storage needs no reset since the pointers define what is live
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: arbitrates ALU and MEM results onto the single RF write port; RF_WB_BYPASS_EN enables same-cycle RAW bypass
module rf_writeback
    import rf_pkg::*;
#(
    parameter int read_ports = 2,
    parameter int fifo_depth = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [AW-1:0]                   alu_dst,
    input  logic [DW-1:0]                   alu_data,
    input  logic                            mem_valid,
    output logic                            mem_ready,
    input  logic [AW-1:0]                   mem_dst,
    input  logic [DW-1:0]                   mem_data,
    output logic                            wr_en      [1],
    output logic [AW-1:0]                   dst        [1],
    output logic [DW-1:0]                   datain     [1],
    input  logic [AW-1:0]                   rd_src     [read_ports],
    input  logic [DW-1:0]                   rf_dataout [read_ports],
    output logic [DW-1:0]                   rd_data    [read_ports],
    output logic [$clog2(fifo_depth+1)-1:0] fifo_count
);
    wb_entry_t  head, win;
    wb_src_e    src;
    logic       full, empty, push, pop;

    wb_fifo #(.DEPTH(fifo_depth)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({alu_dst, alu_data}),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign alu_ready = !full;
    assign mem_ready = !full;

    // fixed-priority winner: a full FIFO drains first, then MEM, then queued ALU, then direct ALU
    always_comb begin
        src  = full ? WB_FIFO : mem_valid ? WB_MEM : !empty ? WB_FIFO : alu_valid ? WB_ALU : WB_NONE;
        win  = src == WB_MEM ? {mem_dst, mem_data} : src == WB_FIFO ? head : {alu_dst, alu_data};
        push = alu_valid && alu_ready && src != WB_ALU;
        pop  = src == WB_FIFO;
    end

    // register the winner onto the RF write port; dst/datain hold while idle
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en[0]  <= 1'b0;
            dst[0]    <= '0;
            datain[0] <= '0;
        end else begin
            wr_en[0] <= src != WB_NONE;
            if (src != WB_NONE) begin
                dst[0]    <= win.dst;
                datain[0] <= win.data;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    // forward the in-flight write to any read port addressing the same register
    always_comb begin
        for (int i = 0; i < read_ports; i++)
            rd_data[i] = (wr_en[0] && rd_src[i] == dst[0]) ? datain[0] : rf_dataout[i];
    end
`else
    logic rd_src_unused;

    // without bypass the RF data passes straight through and rd_src is only folded away
    always_comb begin
        rd_src_unused = 1'b0;
        for (int i = 0; i < read_ports; i++) begin
            rd_data[i]    = rf_dataout[i];
            rd_src_unused = rd_src_unused ^ (^rd_src[i]);
        end
    end
`endif
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed self-checking bench for rf_writeback driving a small RF model
module tb_rf_writeback;
    import rf_pkg::*;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            alu_valid = 1'b0, mem_valid = 1'b0;
    logic            alu_ready, mem_ready;
    logic [AW-1:0]   alu_dst = '0, mem_dst = '0;
    logic [DW-1:0]   alu_data = '0, mem_data = '0;
    logic            wr_en [1];
    logic [AW-1:0]   dst [1];
    logic [DW-1:0]   datain [1];
    logic [AW-1:0]   rd_src [2];
    logic [DW-1:0]   rf_dataout [2];
    logic [DW-1:0]   rd_data [2];
    logic [1:0]      fifo_count;

    logic [DW-1:0]   rf [ENTRIES] = '{default: '0};
    int              n_writes = 0;
    int              checks = 0, errors = 0;

    rf_writeback #(.read_ports(2), .fifo_depth(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_dst    (alu_dst),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_dst    (mem_dst),
        .mem_data   (mem_data),
        .wr_en      (wr_en),
        .dst        (dst),
        .datain     (datain),
        .rd_src     (rd_src),
        .rf_dataout (rf_dataout),
        .rd_data    (rd_data),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    // RF model: commits the write port at the rising edge
    always @(posedge clock) begin
        if (wr_en[0]) begin
            rf[dst[0]] <= datain[0];
            n_writes   <= n_writes + 1;
        end
    end

    // RF read ports
    always_comb begin
        for (int i = 0; i < 2; i++) rf_dataout[i] = rf[rd_src[i]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [AW-1:0] md [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [DW-1:0] mv [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [AW-1:0] ad [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    logic [DW-1:0] av [4] = '{8'h20, 8'h21, 8'h22, 8'h23};
    int            seq [8] = '{0, 1, 4, 2, 5, 3, 6, 7};

    initial begin
        int mi, ai, wi, nw, k;
        logic mf, af, saw_full;
        rd_src[0] = '0;
        rd_src[1] = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_wr_en", wr_en[0], 0);
        chk("rst_dst", dst[0], 0);
        chk("rst_datain", datain[0], 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_mem_ready", mem_ready, 1);

        // single ALU write 3 <- 47
        alu_valid = 1'b1; alu_dst = 2'd3; alu_data = 8'd47;
        tick();
        alu_valid = 1'b0;
        chk("t1_wr_en", wr_en[0], 1);
        chk("t1_dst", dst[0], 3);
        chk("t1_datain", datain[0], 47);
        chk("t1_count", fifo_count, 0);
        rd_src[1] = 2'd3;
        #1;
`ifdef RF_WB_BYPASS_EN
        chk("t5_rd1_inflight", rd_data[1], 47);
`else
        chk("t5_rd1_inflight", rd_data[1], 0);
`endif
        chk("t5_rd0_other", rd_data[0], 0);
        tick();
        chk("t1_rf3", rf[3], 47);
        chk("t5_rd1_after", rd_data[1], 47);

        // idle
        tick(); tick(); tick();
        chk("t6_wr_en", wr_en[0], 0);
        chk("t6_dst_hold", dst[0], 3);
        chk("t6_datain_hold", datain[0], 47);
        chk("t6_rf3", rf[3], 47);
        chk("t6_nwrites", n_writes, 1);

        // MEM and ALU in the same cycle
        mem_valid = 1'b1; mem_dst = 2'd1; mem_data = 8'd5;
        alu_valid = 1'b1; alu_dst = 2'd2; alu_data = 8'd9;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        chk("t2_dst_a", dst[0], 1);
        chk("t2_data_a", datain[0], 5);
        chk("t2_count_a", fifo_count, 1);
        tick();
        chk("t2_wr_en_b", wr_en[0], 1);
        chk("t2_dst_b", dst[0], 2);
        chk("t2_data_b", datain[0], 9);
        chk("t2_count_b", fifo_count, 0);
        tick();
        chk("t2_idle", wr_en[0], 0);
        chk("t2_rf1", rf[1], 5);
        chk("t2_rf2", rf[2], 9);

        // sustained MEM + ALU traffic filling the FIFO
        mi = 0; ai = 0; wi = 0; saw_full = 1'b0;
        for (int c = 0; c < 20 && wi < 8; c++) begin
            mem_valid = mi < 4; mem_dst = md[mi % 4]; mem_data = mv[mi % 4];
            alu_valid = ai < 4; alu_dst = ad[ai % 4]; alu_data = av[ai % 4];
            if (fifo_count == 2'd2 && !alu_ready && !mem_ready) saw_full = 1'b1;
            mf = mem_valid && mem_ready;
            af = alu_valid && alu_ready;
            tick();
            mi += int'(mf);
            ai += int'(af);
            if (wr_en[0]) begin
                k = seq[wi];
                chk($sformatf("t3_dst%0d", wi), dst[0], k < 4 ? md[k] : ad[k-4]);
                chk($sformatf("t3_data%0d", wi), datain[0], k < 4 ? mv[k] : av[k-4]);
                wi++;
            end
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        chk("t3_writes", wi, 8);
        chk("t3_full_seen", saw_full, 1);
        chk("t3_count_end", fifo_count, 0);

        // reset mid-burst with a full FIFO and a pending write
        mem_valid = 1'b1; mem_dst = 2'd1; mem_data = 8'h55;
        alu_valid = 1'b1; alu_dst = 2'd2; alu_data = 8'h66;
        tick();
        tick();
        chk("t4_pre_count", fifo_count, 2);
        chk("t4_pre_wr_en", wr_en[0], 1);
        reset = 1'b1;
        tick();
        chk("t4_wr_en", wr_en[0], 0);
        chk("t4_count", fifo_count, 0);
        chk("t4_dst", dst[0], 0);
        chk("t4_datain", datain[0], 0);
        reset = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
        nw = n_writes;
        tick(); tick(); tick();
        chk("t4_no_writes", n_writes, nw);
        chk("t4_wr_en_idle", wr_en[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
